// File: rtl/vx_ibuffer_pkg.sv
// Shared types for the per-warp instruction buffer: decode payload layout and warp-id sizing.
// Payload fields are packed MSB->LSB in the declaration order below.
package vx_ibuffer_pkg;

    localparam int unsigned NUM_THREADS   = 4;
    localparam int unsigned NUM_WARPS_DEF = 4;
    localparam int unsigned NW_BITS       = $clog2(NUM_WARPS_DEF);

    typedef struct packed {
        logic [NUM_THREADS-1:0] tmask;
        logic [31:0]            pc;
        logic [2:0]             ex_type;
        logic [3:0]             op_type;
        logic [2:0]             op_mod;
        logic                   wb;
        logic [4:0]             rd;
        logic [4:0]             rs1;
        logic [4:0]             rs2;
        logic [4:0]             rs3;
        logic [31:0]            imm;
        logic                   use_pc;
        logic                   use_imm;
        logic [3:0]             used_regs;
    } ibuf_data_t;

    localparam int unsigned IBUF_DATAW = $bits(ibuf_data_t);

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the rotating pointer.
// The pointer moves past the winner only when the grant is consumed (i_en).
module vx_rr_arbiter #(
    parameter int unsigned NUM_REQS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQS-1:0]         i_req,
    input  logic                        i_en,
    output logic                        o_valid,
    output logic [NUM_REQS-1:0]         o_grant,
    output logic [$clog2(NUM_REQS)-1:0] o_grant_idx
);

    localparam int unsigned IdxW = $clog2(NUM_REQS);

    logic [IdxW-1:0] r_ptr;
    logic [IdxW-1:0] w_idx;

    // NUM_REQS is a power of two, so index addition wraps naturally.
    always_comb begin
        o_valid     = 1'b0;
        o_grant_idx = '0;
        w_idx       = '0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            w_idx = r_ptr + IdxW'(i);
            if (!o_valid && i_req[w_idx]) begin
                o_valid     = 1'b1;
                o_grant_idx = w_idx;
            end
        end
    end

    always_comb begin
        o_grant = '0;
        if (o_valid) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_en && o_valid) begin
            r_ptr <= o_grant_idx + IdxW'(1);
        end
    end

endmodule

// File: rtl/vx_ibuffer.sv
// Per-warp instruction buffer between decode and issue: one small FIFO per warp feeding a
// single registered output slot, with round-robin warp selection.
module vx_ibuffer
    import vx_ibuffer_pkg::*;
#(
    parameter int unsigned NUM_WARPS = 4,
    parameter int unsigned IBUF_SIZE = 2,
    parameter int unsigned DATAW     = IBUF_DATAW
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [$clog2(NUM_WARPS)-1:0] in_wid,
    input  logic [DATAW-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [$clog2(NUM_WARPS)-1:0] out_wid,
    output logic [DATAW-1:0]             out_data,
    input  logic                         out_ready,
    output logic [NUM_WARPS-1:0]         empty_mask
);

    localparam int unsigned NwW  = $clog2(NUM_WARPS);
    localparam int unsigned PtrW = $clog2(IBUF_SIZE);
    localparam int unsigned CntW = $clog2(IBUF_SIZE) + 1;

    logic [CntW-1:0]      w_count [NUM_WARPS];
    logic [DATAW-1:0]     w_head  [NUM_WARPS];
    logic [NUM_WARPS-1:0] w_push;
    logic [NUM_WARPS-1:0] w_pop;
    logic [NUM_WARPS-1:0] w_grant;
    logic [NwW-1:0]       w_grant_idx;
    logic                 w_any;
    logic                 w_in_fire;
    logic                 w_load;

    // Full check uses registered count only, so a same-cycle pop never frees a slot early.
    assign in_ready  = (w_count[in_wid] != CntW'(IBUF_SIZE));
    assign w_in_fire = in_valid && in_ready;
    assign w_load    = (!out_valid || out_ready) && w_any;

    vx_rr_arbiter #(
        .NUM_REQS (NUM_WARPS)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_req       (~empty_mask),
        .i_en        (w_load),
        .o_valid     (w_any),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    for (genvar w = 0; w < int'(NUM_WARPS); w++) begin : g_warp
        logic [DATAW-1:0] r_mem [IBUF_SIZE];
        logic [PtrW-1:0]  r_wptr;
        logic [PtrW-1:0]  r_rptr;
        logic [CntW-1:0]  r_count;
        logic [CntW-1:0]  w_count_d;

        assign w_push[w]     = w_in_fire && (in_wid == NwW'(w));
        assign w_pop[w]      = w_load && w_grant[w];
        assign w_count[w]    = r_count;
        assign w_head[w]     = r_mem[r_rptr];
        assign empty_mask[w] = (r_count == '0);

        always_comb begin
            w_count_d = r_count;
            unique case ({w_push[w], w_pop[w]})
                2'b10:   w_count_d = r_count + CntW'(1);
                2'b01:   w_count_d = r_count - CntW'(1);
                default: w_count_d = r_count;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push[w]) begin
                    r_wptr <= r_wptr + PtrW'(1);
                end
                if (w_pop[w]) begin
                    r_rptr <= r_rptr + PtrW'(1);
                end
                r_count <= w_count_d;
            end
        end

        // Storage needs no reset; validity is tracked by the count.
        always_ff @(posedge clk) begin
            if (w_push[w]) begin
                r_mem[r_wptr] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_wid   <= '0;
            out_data  <= '0;
        end else if (w_load) begin
            out_valid <= 1'b1;
            out_wid   <= w_grant_idx;
            out_data  <= w_head[w_grant_idx];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vx_ibuffer.sv
// Directed self-checking bench for vx_ibuffer: reset, latency/order, backpressure,
// round-robin order, streaming push/pop and output stall hold.
module tb_vx_ibuffer;
    import vx_ibuffer_pkg::*;

    localparam int unsigned NW    = 4;
    localparam int unsigned DATAW = IBUF_DATAW;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [1:0]       in_wid;
    logic [DATAW-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [1:0]       out_wid;
    logic [DATAW-1:0] out_data;
    logic             out_ready;
    logic [NW-1:0]    empty_mask;

    int n_checks;
    int n_fail;

    vx_ibuffer #(
        .NUM_WARPS (NW),
        .IBUF_SIZE (2),
        .DATAW     (DATAW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_wid     (in_wid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_wid    (out_wid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .empty_mask (empty_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATAW-1:0] mk(input logic [31:0] pc);
        ibuf_data_t d;
        d           = '0;
        d.tmask     = 4'hF;
        d.pc        = pc;
        d.imm       = ~pc;
        d.rd        = pc[6:2];
        d.used_regs = pc[3:0] ^ 4'h5;
        return d;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] wid, input logic [31:0] pc);
        in_valid = 1'b1;
        in_wid   = wid;
        in_data  = mk(pc);
    endtask

    typedef struct {
        logic [1:0]  wid;
        logic [31:0] pc;
    } exp_t;

    exp_t rr_exp [6];
    exp_t hold_exp [5];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_wid    = 2'd0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();

        check_eq("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check_eq("rst_out_wid", 128'(out_wid), 128'(2'd0));
        check_eq("rst_out_data", 128'(out_data), 128'(0));
        check_eq("rst_empty", 128'(empty_mask), 128'(4'b1111));
        check_eq("rst_in_ready", 128'(in_ready), 128'(1'b1));

        // Reset mid-stream: slot holds 0x10, warp 1 holds two more.
        reset = 1'b0;
        push(2'd1, 32'h10);
        tick();
        push(2'd1, 32'h14);
        tick();
        push(2'd1, 32'h18);
        tick();
        in_valid = 1'b0;
        #1;
        check_eq("mid_empty", 128'(empty_mask), 128'(4'b1101));
        check_eq("mid_in_ready_full", 128'(in_ready), 128'(1'b0));
        check_eq("mid_out_data", 128'(out_data), 128'(mk(32'h10)));
        reset = 1'b1;
        #1;
        check_eq("async_rst_valid", 128'(out_valid), 128'(1'b0));
        check_eq("async_rst_empty", 128'(empty_mask), 128'(4'b1111));
        tick();
        reset = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 128'(in_ready), 128'(1'b1));
        check_eq("post_rst_valid", 128'(out_valid), 128'(1'b0));
        check_eq("post_rst_empty", 128'(empty_mask), 128'(4'b1111));

        // Single-warp latency and order.
        out_ready = 1'b1;
        push(2'd0, 32'h100);
        tick();
        check_eq("lat_not_yet", 128'(out_valid), 128'(1'b0));
        push(2'd0, 32'h104);
        tick();
        in_valid = 1'b0;
        check_eq("lat_valid", 128'(out_valid), 128'(1'b1));
        check_eq("lat_wid", 128'(out_wid), 128'(2'd0));
        check_eq("lat_data0", 128'(out_data), 128'(mk(32'h100)));
        tick();
        check_eq("lat_data1", 128'(out_data), 128'(mk(32'h104)));
        tick();
        check_eq("lat_drained", 128'(out_valid), 128'(1'b0));
        check_eq("lat_empty", 128'(empty_mask), 128'(4'b1111));

        // Full backpressure on warp 2.
        out_ready = 1'b0;
        push(2'd2, 32'h200);
        tick();
        push(2'd2, 32'h204);
        tick();
        push(2'd2, 32'h208);
        tick();
        in_valid = 1'b0;
        #1;
        check_eq("bp_ready_w2", 128'(in_ready), 128'(1'b0));
        in_wid = 2'd3;
        #1;
        check_eq("bp_ready_w3", 128'(in_ready), 128'(1'b1));
        in_wid = 2'd2;
        #1;
        check_eq("bp_slot", 128'(out_data), 128'(mk(32'h200)));
        check_eq("bp_empty", 128'(empty_mask), 128'(4'b1011));
        out_ready = 1'b1;
        tick();
        check_eq("bp_ready_back", 128'(in_ready), 128'(1'b1));
        check_eq("bp_data1", 128'(out_data), 128'(mk(32'h204)));
        tick();
        check_eq("bp_data2", 128'(out_data), 128'(mk(32'h208)));
        check_eq("bp_empty_after", 128'(empty_mask), 128'(4'b1111));
        tick();
        check_eq("bp_drained", 128'(out_valid), 128'(1'b0));

        // Round-robin: slot takes w0 first, then 1,3,0,1,3,0 drain order.
        out_ready = 1'b0;
        push(2'd0, 32'h300);
        tick();
        push(2'd0, 32'h304);
        tick();
        push(2'd1, 32'h310);
        tick();
        push(2'd1, 32'h314);
        tick();
        push(2'd3, 32'h330);
        tick();
        push(2'd3, 32'h334);
        tick();
        push(2'd0, 32'h308);
        tick();
        in_valid = 1'b0;
        check_eq("rr_first_wid", 128'(out_wid), 128'(2'd0));
        check_eq("rr_first_data", 128'(out_data), 128'(mk(32'h300)));
        rr_exp[0] = '{2'd1, 32'h310};
        rr_exp[1] = '{2'd3, 32'h330};
        rr_exp[2] = '{2'd0, 32'h304};
        rr_exp[3] = '{2'd1, 32'h314};
        rr_exp[4] = '{2'd3, 32'h334};
        rr_exp[5] = '{2'd0, 32'h308};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq($sformatf("rr_wid%0d", i), 128'(out_wid), 128'(rr_exp[i].wid));
            check_eq($sformatf("rr_data%0d", i), 128'(out_data), 128'(mk(rr_exp[i].pc)));
        end
        tick();
        check_eq("rr_drained", 128'(out_valid), 128'(1'b0));

        // Streaming push/pop on warp 1.
        for (int i = 0; i < 8; i++) begin
            push(2'd1, 32'h500 + 32'(4 * i));
            #1;
            check_eq($sformatf("st_ready%0d", i), 128'(in_ready), 128'(1'b1));
            tick();
            if (i > 0) begin
                check_eq($sformatf("st_data%0d", i), 128'(out_data),
                         128'(mk(32'h500 + 32'(4 * (i - 1)))));
                check_eq($sformatf("st_cnt1_%0d", i), 128'(dut.g_warp[1].r_count), 128'(2'd1));
            end
        end
        in_valid = 1'b0;
        tick();
        check_eq("st_last", 128'(out_data), 128'(mk(32'h51c)));
        tick();
        check_eq("st_drained", 128'(out_valid), 128'(1'b0));

        // Stall hold while other warps push.
        out_ready = 1'b0;
        push(2'd2, 32'h600);
        tick();
        in_valid = 1'b0;
        tick();
        hold_exp[0] = '{2'd0, 32'h700};
        hold_exp[1] = '{2'd3, 32'h704};
        hold_exp[2] = '{2'd1, 32'h708};
        hold_exp[3] = '{2'd0, 32'h70c};
        hold_exp[4] = '{2'd3, 32'h710};
        for (int i = 0; i < 5; i++) begin
            push(hold_exp[i].wid, hold_exp[i].pc);
            tick();
            check_eq($sformatf("hold_wid%0d", i), 128'(out_wid), 128'(2'd2));
            check_eq($sformatf("hold_data%0d", i), 128'(out_data), 128'(mk(32'h600)));
        end
        in_valid = 1'b0;
        #1;
        check_eq("hold_empty", 128'(empty_mask), 128'(4'b0100));
        out_ready = 1'b1;
        // Pointer sits at 3 after warp 2 won: 3,0,1,3,0.
        rr_exp[0] = hold_exp[1];
        rr_exp[1] = hold_exp[0];
        rr_exp[2] = hold_exp[2];
        rr_exp[3] = hold_exp[4];
        rr_exp[4] = hold_exp[3];
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("hd_wid%0d", i), 128'(out_wid), 128'(rr_exp[i].wid));
            check_eq($sformatf("hd_data%0d", i), 128'(out_data), 128'(mk(rr_exp[i].pc)));
        end
        tick();
        check_eq("hd_drained", 128'(out_valid), 128'(1'b0));
        check_eq("hd_empty", 128'(empty_mask), 128'(4'b1111));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
